// File: rtl/timer_pkg.sv
// Shared constants for the preset timer register and its users.
package timer_pkg;

    // Count direction selected by the mode input.
    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    // Default count width, matching the original fixed 8-bit register.
    localparam int DEFAULT_WIDTH = 8;

endpackage : timer_pkg

// File: rtl/preset_reg.sv
// WIDTH-bit register with asynchronous active-high reset to a port-supplied
// value and a synchronous write enable. Built bit by bit so each flop can
// take its own reset value from rst_val.
module preset_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        // One flop per bit: preset from rst_val, load d when enabled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_q[gi] <= rst_val[gi];
            end else if (en) begin
                q_q[gi] <= d[gi];
            end
        end
    end

    assign q = q_q;

endmodule : preset_reg

// File: rtl/preset_timer_reg.sv
// Preset timer register: asynchronously preset count with synchronous load,
// tick-gated up/down stepping against a programmable limit, optional
// auto-reload, a one-cycle terminal-count pulse and a sticky done flag.
module preset_timer_reg
    import timer_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] reset_val,
    input  logic             en,
    input  logic             tick,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_done,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             cnt_we_s;
    logic             step_s;
    logic             tc_q;
    logic             tc_d;
    logic             done_q;
    logic             done_d;

    // A step needs both enable and tick; load pre-empts it.
    assign step_s = en && tick && !load;

    // Next-state: load beats step beats hold; terminal handling per mode.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_we_s = 1'b0;
        tc_d     = 1'b0;
        // clr_done applies unless a terminal step below sets done again.
        if (clr_done) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (load) begin
            cnt_d    = load_val;
            cnt_we_s = 1'b1;
            done_d   = 1'b0;
        end else if (step_s) begin
            case (mode)
                MODE_DOWN: begin
                    if (cnt_q != ZERO) begin
                        cnt_d    = cnt_q - ONE;
                        cnt_we_s = 1'b1;
                    end else if (AUTO_RELOAD) begin
                        cnt_d    = limit;
                        cnt_we_s = 1'b1;
                        tc_d     = 1'b1;
                    end else begin
                        // Parked at zero: pulse only on the first arrival.
                        done_d = 1'b1;
                        tc_d   = !done_q;
                    end
                end
                MODE_UP: begin
                    // q above limit is terminal too, so no wrap at 2^WIDTH.
                    if (cnt_q < limit) begin
                        cnt_d    = cnt_q + ONE;
                        cnt_we_s = 1'b1;
                    end else if (AUTO_RELOAD) begin
                        cnt_d    = ZERO;
                        cnt_we_s = 1'b1;
                        tc_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        tc_d   = !done_q;
                    end
                end
                default: begin
                    cnt_d    = cnt_q;
                    cnt_we_s = 1'b0;
                end
            endcase
        end else begin
            cnt_d    = cnt_q;
            cnt_we_s = 1'b0;
        end
    end

    preset_reg #(
        .WIDTH (WIDTH)
    ) u_cnt_reg (
        .clk     (clk),
        .rst     (rst),
        .rst_val (reset_val),
        .en      (cnt_we_s),
        .d       (cnt_d),
        .q       (cnt_q)
    );

    // Terminal-count pulse and sticky done flag, both cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_q   <= tc_d;
            done_q <= done_d;
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule : preset_timer_reg

// File: tb/tb_preset_timer_reg.sv
// Directed bench for preset_timer_reg. Three instances share the control
// inputs: u_stop (8-bit, stop at terminal), u_rel (8-bit, auto-reload) and
// u_w12 (12-bit, auto-reload). Each directed step checks only the instance
// it targets, after reloading it to a known value.
module tb_preset_timer_reg;

    logic        clk;
    logic        rst;
    logic        en;
    logic        tick;
    logic        mode;
    logic        load;
    logic        clr_done;
    logic [7:0]  reset_val;
    logic [7:0]  load_val;
    logic [7:0]  limit;
    logic [11:0] reset_val12;
    logic [11:0] load_val12;
    logic [11:0] limit12;

    logic [7:0]  q_stop;
    logic        tc_stop;
    logic        done_stop;
    logic [7:0]  q_rel;
    logic        tc_rel;
    logic        done_rel;
    logic [11:0] q_w12;
    logic        tc_w12;
    logic        done_w12;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q  [0:6];
    logic       exp_tc [0:6];

    preset_timer_reg #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_stop (
        .clk(clk), .rst(rst), .reset_val(reset_val), .en(en), .tick(tick),
        .mode(mode), .load(load), .load_val(load_val), .limit(limit),
        .clr_done(clr_done), .q(q_stop), .tc(tc_stop), .done(done_stop)
    );

    preset_timer_reg #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_rel (
        .clk(clk), .rst(rst), .reset_val(reset_val), .en(en), .tick(tick),
        .mode(mode), .load(load), .load_val(load_val), .limit(limit),
        .clr_done(clr_done), .q(q_rel), .tc(tc_rel), .done(done_rel)
    );

    preset_timer_reg #(.WIDTH(12), .AUTO_RELOAD(1'b1)) u_w12 (
        .clk(clk), .rst(rst), .reset_val(reset_val12), .en(en), .tick(tick),
        .mode(mode), .load(load), .load_val(load_val12), .limit(limit12),
        .clr_done(clr_done), .q(q_w12), .tc(tc_w12), .done(done_w12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; tick = 1'b0; mode = 1'b0; load = 1'b0;
        clr_done = 1'b0;
        reset_val = 8'h3C; load_val = 8'h00; limit = 8'h00;
        reset_val12 = 12'hABC; load_val12 = 12'h000; limit12 = 12'hFFF;

        // Reset pulse between edges: q presets without any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_q", {24'h0, q_stop}, 32'h3C);
        chk("rst_tc", {31'h0, tc_stop}, 32'h0);
        chk("rst_done", {31'h0, done_stop}, 32'h0);
        chk("rst_q_rel", {24'h0, q_rel}, 32'h3C);
        #1 rst = 1'b0;
        tick = 1'b1;
        step();
        step();
        chk("hold_en0", {24'h0, q_stop}, 32'h3C);

        // Countdown, stop at terminal.
        tick = 1'b0; mode = 1'b0; load_val = 8'd3; load = 1'b1;
        step();
        load = 1'b0;
        chk("cd_load", {24'h0, q_stop}, 32'd3);
        exp_q[0] = 8'd2; exp_q[1] = 8'd1; exp_q[2] = 8'd0; exp_q[3] = 8'd0; exp_q[4] = 8'd0;
        exp_tc[0] = 1'b0; exp_tc[1] = 1'b0; exp_tc[2] = 1'b0; exp_tc[3] = 1'b1; exp_tc[4] = 1'b0;
        en = 1'b1; tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("cd_q%0d", i), {24'h0, q_stop}, {24'h0, exp_q[i]});
            chk($sformatf("cd_tc%0d", i), {31'h0, tc_stop}, {31'h0, exp_tc[i]});
            chk($sformatf("cd_done%0d", i), {31'h0, done_stop}, (i >= 3) ? 32'h1 : 32'h0);
        end
        tick = 1'b0; clr_done = 1'b1;
        step();
        clr_done = 1'b0;
        chk("cd_clr_done", {31'h0, done_stop}, 32'h0);
        chk("cd_clr_tc", {31'h0, tc_stop}, 32'h0);

        // Countdown with auto-reload, limit 2, from 0.
        limit = 8'd2; load_val = 8'd0; load = 1'b1;
        step();
        load = 1'b0;
        exp_q[0] = 8'd2; exp_q[1] = 8'd1; exp_q[2] = 8'd0; exp_q[3] = 8'd2;
        exp_q[4] = 8'd1; exp_q[5] = 8'd0; exp_q[6] = 8'd2;
        exp_tc[0] = 1'b1; exp_tc[1] = 1'b0; exp_tc[2] = 1'b0; exp_tc[3] = 1'b1;
        exp_tc[4] = 1'b0; exp_tc[5] = 1'b0; exp_tc[6] = 1'b1;
        tick = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("rl_q%0d", i), {24'h0, q_rel}, {24'h0, exp_q[i]});
            chk($sformatf("rl_tc%0d", i), {31'h0, tc_rel}, {31'h0, exp_tc[i]});
            chk($sformatf("rl_done%0d", i), {31'h0, done_rel}, 32'h0);
        end

        // Limit 0, down, auto-reload: tc on every step, q stays 0.
        tick = 1'b0; limit = 8'd0; load_val = 8'd0; load = 1'b1;
        step();
        load = 1'b0; tick = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("lim0_q%0d", i), {24'h0, q_rel}, 32'h0);
            chk($sformatf("lim0_tc%0d", i), {31'h0, tc_rel}, 32'h1);
        end

        // Up mode from above the limit: terminal at once, then 1..5, wrap.
        tick = 1'b0; mode = 1'b1; limit = 8'd5; load_val = 8'd9; load = 1'b1;
        step();
        load = 1'b0; tick = 1'b1;
        step();
        chk("up_oor_q", {24'h0, q_rel}, 32'h0);
        chk("up_oor_tc", {31'h0, tc_rel}, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("up_q%0d", i), {24'h0, q_rel}, i);
            chk($sformatf("up_tc%0d", i), {31'h0, tc_rel}, 32'h0);
        end
        step();
        chk("up_wrap_q", {24'h0, q_rel}, 32'h0);
        chk("up_wrap_tc", {31'h0, tc_rel}, 32'h1);

        // Priority: get u_stop to done, then load together with a tick.
        tick = 1'b0; mode = 1'b0; load_val = 8'd1; load = 1'b1;
        step();
        load = 1'b0; tick = 1'b1;
        step();
        step();
        chk("pr_done_set", {31'h0, done_stop}, 32'h1);
        load_val = 8'h07; load = 1'b1;
        step();
        load = 1'b0;
        chk("pr_load_q", {24'h0, q_stop}, 32'h07);
        chk("pr_load_tc", {31'h0, tc_stop}, 32'h0);
        chk("pr_load_done", {31'h0, done_stop}, 32'h0);
        en = 1'b0;
        step();
        chk("pr_en0_q", {24'h0, q_stop}, 32'h07);

        // clr_done with a terminal step in the same cycle: set wins.
        load_val = 8'd0; load = 1'b1; tick = 1'b0;
        step();
        load = 1'b0; en = 1'b1; tick = 1'b1; clr_done = 1'b1;
        step();
        clr_done = 1'b0;
        chk("pr_clr_set_done", {31'h0, done_stop}, 32'h1);
        chk("pr_clr_set_tc", {31'h0, tc_stop}, 32'h1);
        step();
        chk("pr_after_done_tc", {31'h0, tc_stop}, 32'h0);

        // 12-bit: count up to 0x010, then async reset off-edge.
        tick = 1'b0; mode = 1'b1; limit12 = 12'hFFF; load_val12 = 12'h00F; load = 1'b1;
        step();
        load = 1'b0; tick = 1'b1;
        step();
        chk("w12_q", {20'h0, q_w12}, 32'h010);
        #2 rst = 1'b1;
        #1;
        chk("w12_rst_q", {20'h0, q_w12}, 32'hABC);
        chk("w12_rst_tc", {31'h0, tc_w12}, 32'h0);
        chk("w12_rst_done", {31'h0, done_w12}, 32'h0);
        #1 rst = 1'b0;
        step();
        chk("w12_after_rst", {20'h0, q_w12}, 32'hABD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_preset_timer_reg

// File: doc/preset_timer_reg.md
Name: preset_timer_reg

Overview:
Parametrised successor to the fixed 8-bit preset-reset register used in the two-mode timer. It holds a WIDTH-bit value that resets asynchronously to a port-supplied value. It adds synchronous load, a tick-gated up/down count with a programmable limit, optional auto-reload, a terminal-count pulse and a sticky done flag. It sits between the prescaler (tick source) and the display/BCD stage, and provides both timer modes: countdown and stopwatch.

Parameters:
WIDTH, 8, bit width of count, reset_val, load_val, limit
AUTO_RELOAD, 0, 1 = roll over at terminal and keep running; 0 = stop at terminal and set done

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
reset_val  input  WIDTH  value forced onto q while rst is high; must be stable while rst is asserted
en  input  1  count enable (run/pause)
tick  input  1  single-cycle step strobe from prescaler; a step occurs only when en && tick
mode  input  1  0 = count down (timer), 1 = count up (stopwatch)
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written on load
limit  input  WIDTH  down mode: reload value; up mode: terminal value
clr_done  input  1  synchronous clear of done
q  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  sticky terminal flag (registered)

Behaviour:
- Reset (async, rst=1): q = reset_val, tc = 0, done = 0, applied immediately regardless of clk. After rst deasserts, q holds reset_val until the first qualifying edge.
- Per-edge priority: load > step > hold.
- Load:
  - q <= load_val, done <= 0, tc <= 0.
  - Any step in the same cycle is discarded.
- Step (en && tick && !load), down mode:
  - q != 0: q <= q-1.
  - q == 0 and AUTO_RELOAD=1: q <= limit, tc <= 1.
  - q == 0 and AUTO_RELOAD=0: q holds 0, done <= 1, tc <= 1 only on the first step at 0 (i.e. only while done was 0).
- Step, up mode:
  - q < limit: q <= q+1.
  - q >= limit and AUTO_RELOAD=1: q <= 0, tc <= 1.
  - q >= limit and AUTO_RELOAD=0: q holds, done <= 1, tc <= 1 only if done was 0.
  - q > limit (e.g. after a load or a limit change) counts as terminal, so up mode never wraps through 2^WIDTH.
- tc is 0 in every cycle not listed above; its maximum width is one clk.
- done stays set until load or clr_done. If clr_done and a terminal step occur in the same cycle, done <= 1 (set wins).
- With AUTO_RELOAD=0 and done=1, further steps leave q unchanged and produce no tc.
- No step when en=0 or tick=0; a tick while en=0 is lost, not queued.
- Changing mode mid-count leaves q unchanged; the next step follows the new mode.
- Changing limit takes effect from the next step.
- limit = 0:
  - Down mode with AUTO_RELOAD=1 gives tc on every step, with q staying 0.
  - Up mode is terminal immediately.
- Arithmetic is WIDTH-bit unsigned; no wrap through 0 or 2^WIDTH-1 except the defined reloads.
- Latency: q and tc change on the same edge as the qualifying step; no pipeline.
- rst asserted mid-count aborts immediately to the reset values above; there is no partial state.

Decomposition:
- Shared package timer_pkg holds the mode constants MODE_DOWN=1'b0 and MODE_UP=1'b1, and the default WIDTH.
- One sub-module is natural: preset_reg, a WIDTH-parametrised register with asynchronous active-high reset to a port value and a synchronous enable, generated per bit. preset_timer_reg instantiates one preset_reg for q. tc and done are plain registers with reset 0. Next-state and terminal logic stay in the top module.

Test Plan:
- Reset value: WIDTH=8, reset_val=8'h3C, pulse rst between edges -> q=8'h3C immediately with no clk edge; tc=0, done=0; q holds 8'h3C with en=0.
- Countdown stop: AUTO_RELOAD=0, mode=0, load_val=3, load, then 5 qualifying ticks -> q=2,1,0,0,0; tc high for exactly one cycle on the 4th tick; done=1 from the 4th tick onward; clr_done -> done=0, no new tc.
- Countdown reload: AUTO_RELOAD=1, limit=2, q=0, 7 ticks -> q=2,1,0,2,1,0,2; tc pulses on ticks 1, 4 and 7; done stays 0.
- Up with out-of-range start: AUTO_RELOAD=1, mode=1, limit=5, load_val=9 -> first tick gives q=0 with tc=1; then 5 ticks -> q=1..5; next tick -> q=0 with tc=1.
- Priority and gating:
  - load and tick in the same cycle -> q=load_val, no tc, done cleared.
  - tick with en=0 -> q unchanged.
  - clr_done together with a terminal step -> done=1.
- Async reset mid-count: WIDTH=12, reset_val=12'hABC, counting up at q=12'h010, assert rst off-edge -> q=12'hABC at once, tc=0, done=0; after release, the next tick gives 12'hABD.
